dma_axi_mm_write_engine: RTL and testbench
==========================================

DMA_AXI_MM_WRITE_ENGINE -- requirements
Module: dma_axi_mm_write_engine

Interface
REQ-001 SHALL have parameter ADDR_W, default 48: destination address width.
REQ-002 SHALL have parameter DATA_W, default 512: data beat width; one beat = 64 bytes.
REQ-003 SHALL have parameter MAX_BURST, default 16: maximum beats per AXI burst.
REQ-004 SHALL have the following ports, listed as name  direction  width  meaning:
- clk  in  1  single clock.
- reset_n  in  1  reset, asynchronous, active-low.
- desc_valid  in  1  descriptor offered.
- desc_ready  out  1  descriptor accepted.
- desc_dest_addr  in  ADDR_W  destination byte address.
- desc_length  in  20  transfer length in bytes.
- src_valid  in  1  read-side data FIFO beat valid.
- src_ready  out  1  beat consumed.
- src_data  in  DATA_W  beat payload.
- awvalid / awready  out / in  1 / 1  AXI write-address handshake.
- awaddr  out  ADDR_W  burst start address.
- awlen  out  8  beats minus 1.
- wvalid / wready  out / in  1 / 1  AXI write-data handshake.
- wdata  out  DATA_W  write payload.
- wstrb  out  DATA_W/8  byte enables.
- wlast  out  1  last beat of burst.
- bvalid / bready  in / out  1 / 1  AXI write-response handshake.
- bresp  in  2  OKAY=0, EXOKAY=1, SLVERR=2, DECERR=3.
- busy  out  1  descriptor in progress.
- done  out  1  one-cycle completion pulse.
- wr_rsp_err  out  1  sticky error flag for the current descriptor.
- wr_resp_enc  out  2  first non-OKAY bresp seen.
- wr_state  out  6  one-hot FSM state.
- wr_dest_clk_cnt  out  32  busy cycles.
- wr_dest_valid_cnt  out  32  W handshakes.

Function
REQ-005 SHALL implement a one-hot FSM driving wr_state: IDLE=bit0, ADDR=bit1, DATA=bit2, RESP=bit3, DONE=bit4, ERROR=bit5.
REQ-006 SHALL assert desc_ready only in IDLE; on accept it SHALL latch the address with bits [5:0] forced to 0, set beats = ceil(length/64), clear both counters, wr_rsp_err and wr_resp_enc, and go to ADDR, or go to DONE if length = 0.
REQ-007 SHALL size each burst as min(remaining beats, MAX_BURST, beats to the next 4 KB boundary); awlen = size-1; awvalid SHALL hold with stable payload until awready, then go to DATA.
REQ-008 SHALL drive wvalid = src_valid and src_ready = wready in DATA only (zero-bubble pass-through); wdata = src_data.
REQ-009 SHALL assert wlast on the final beat of each burst; after that beat's handshake it SHALL go to ADDR if beats remain, else to RESP.
REQ-010 SHALL set wstrb to all-ones except on the last beat of the descriptor when length[5:0] != 0, where wstrb = (1 << length[5:0]) - 1.
REQ-011 SHALL hold bready = 1 in every state; an outstanding-burst counter (15 bits) SHALL increment on AW handshake and decrement on B handshake, and be unchanged when both occur in the same cycle.
REQ-012 SHALL, in RESP, go to DONE when outstanding = 0 and no error has been seen.
REQ-013 SHALL, on any B handshake with bresp != OKAY, set wr_rsp_err, capture wr_resp_enc (first error only) and enter ERROR at the next burst boundary (immediately if in ADDR or RESP; in DATA only after the wlast beat).
REQ-014 SHALL, in ERROR, issue no new AW and consume no src beats, wait until outstanding = 0, then go to DONE.
REQ-015 SHALL pulse done for exactly one cycle in DONE, then return to IDLE; busy = 1 in every state except IDLE.
REQ-016 SHALL increment wr_dest_clk_cnt every busy cycle and wr_dest_valid_cnt every W handshake; both SHALL saturate at 32'hFFFF_FFFF.

Reset
REQ-017 SHALL, when reset_n is low, immediately force IDLE (wr_state = 6'b000001) and drive all valid/ready/done/busy/wlast/error outputs to 0 and all counters and registers to 0; reset_n deasserted mid-transfer abandons that transfer with no done pulse.

Verification
REQ-018 SHALL verify: addr 0x1000, length 2048 -> two AW bursts with awlen = 15 at 0x1000 and 0x1400, 32 W beats, all wstrb all-ones, one done pulse, valid_cnt = 32.
REQ-019 SHALL verify: addr 0x0FC0, length 256 -> bursts awlen = 0 at 0x0FC0 and awlen = 2 at 0x1000, with no burst crossing the 4 KB boundary.
REQ-020 SHALL verify: length 100 -> awlen = 1, last-beat wstrb = 64'h0000_000F_FFFF_FFFF.
REQ-021 SHALL verify: SLVERR on the first of 4 bursts -> wr_rsp_err = 1, wr_resp_enc = 2, no further AW issued, done only after all outstanding B responses are received.
REQ-022 SHALL verify: length 0 -> done 2 cycles after desc accept with no AXI traffic; separately, reset_n asserted in DATA -> all outputs 0 within the same cycle and no done pulse.
REQ-023 SHALL verify: src_valid toggling and wready stalls -> beat order preserved, and an AW handshake coinciding with a B handshake leaves the outstanding counter unchanged.

Source files
------------

// File: rtl/dma_axi_mm_write_engine.sv
// AXI4 memory-mapped write engine: splits one descriptor into 4 KB-safe bursts
// and passes read-side FIFO beats straight through onto the W channel.
module dma_axi_mm_write_engine #(
   parameter int ADDR_W    = 48,
   parameter int DATA_W    = 512,
   parameter int MAX_BURST = 16
) (
   input  logic                clk,
   input  logic                reset_n,
   input  logic                desc_valid,
   output logic                desc_ready,
   input  logic [ADDR_W-1:0]   desc_dest_addr,
   input  logic [19:0]         desc_length,
   input  logic                src_valid,
   output logic                src_ready,
   input  logic [DATA_W-1:0]   src_data,
   output logic                awvalid,
   input  logic                awready,
   output logic [ADDR_W-1:0]   awaddr,
   output logic [7:0]          awlen,
   output logic                wvalid,
   input  logic                wready,
   output logic [DATA_W-1:0]   wdata,
   output logic [DATA_W/8-1:0] wstrb,
   output logic                wlast,
   input  logic                bvalid,
   output logic                bready,
   input  logic [1:0]          bresp,
   output logic                busy,
   output logic                done,
   output logic                wr_rsp_err,
   output logic [1:0]          wr_resp_enc,
   output logic [5:0]          wr_state,
   output logic [31:0]         wr_dest_clk_cnt,
   output logic [31:0]         wr_dest_valid_cnt
);
   localparam int STRB_W = DATA_W / 8;

   typedef enum logic [5:0] {
      S_IDLE  = 6'b000001,
      S_ADDR  = 6'b000010,
      S_DATA  = 6'b000100,
      S_RESP  = 6'b001000,
      S_DONE  = 6'b010000,
      S_ERROR = 6'b100000
   } state_t;

   state_t            state;
   logic              armed;
   logic [ADDR_W-1:0] cur_addr;
   logic [14:0]       beats_left;
   logic [7:0]        burst_left;
   logic [5:0]        tail_bytes;
   logic [14:0]       outstanding;
   logic [6:0]        to_boundary;
   logic [14:0]       burst_size;
   logic [STRB_W-1:0] tail_mask;
   logic              accept;
   logic              aw_hs;
   logic              w_hs;
   logic              b_hs;
   logic              b_err;
   logic              err_now;

   // Burst length is capped by what is left, MAX_BURST, and the next 4 KB page edge.
   always_comb begin
      to_boundary = 7'd64 - {1'b0, cur_addr[11:6]};
      burst_size  = beats_left;
      if (burst_size > 15'(MAX_BURST))
         burst_size = 15'(MAX_BURST);
      if (burst_size > {8'd0, to_boundary})
         burst_size = {8'd0, to_boundary};
   end

   assign accept  = desc_valid && desc_ready;
   assign aw_hs   = awvalid && awready;
   assign w_hs    = wvalid && wready;
   assign b_hs    = bvalid && bready;
   assign b_err   = b_hs && (bresp != 2'b00);
   assign err_now = wr_rsp_err || b_err;

   // 'armed' keeps every ready low until the first edge after reset release.
   assign desc_ready = armed && (state == S_IDLE);
   assign bready     = armed;
   assign awvalid    = (state == S_ADDR);
   assign awaddr     = awvalid ? cur_addr : '0;
   assign awlen      = awvalid ? 8'(burst_size - 15'd1) : 8'd0;
   assign wvalid     = (state == S_DATA) && src_valid;
   assign src_ready  = (state == S_DATA) && wready;
   assign wdata      = src_data;
   assign wlast      = (state == S_DATA) && (burst_left == 8'd1);
   assign tail_mask  = (STRB_W'(1) << tail_bytes) - STRB_W'(1);
   assign wstrb      = (state != S_DATA) ? '0 :
                       ((beats_left == 15'd1) && (tail_bytes != 6'd0)) ? tail_mask : '1;
   assign busy       = (state != S_IDLE);
   assign wr_state   = state;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state       <= S_IDLE;
         armed       <= 1'b0;
         cur_addr    <= '0;
         beats_left  <= '0;
         burst_left  <= '0;
         tail_bytes  <= '0;
         done        <= 1'b0;
         wr_rsp_err  <= 1'b0;
         wr_resp_enc <= 2'b00;
      end else begin
         armed <= 1'b1;
         done  <= (state == S_DONE);
         if (b_err && !wr_rsp_err) begin
            wr_rsp_err  <= 1'b1;
            wr_resp_enc <= bresp;
         end
         case (state)
            S_IDLE: begin
               if (accept) begin
                  cur_addr    <= desc_dest_addr & ~ADDR_W'(6'h3F);
                  beats_left  <= {1'b0, desc_length[19:6]} + 15'(|desc_length[5:0]);
                  tail_bytes  <= desc_length[5:0];
                  wr_rsp_err  <= 1'b0;
                  wr_resp_enc <= 2'b00;
                  state       <= (desc_length == 20'd0) ? S_DONE : S_ADDR;
               end
            end
            S_ADDR: begin
               if (aw_hs) begin
                  burst_left <= 8'(burst_size);
                  cur_addr   <= cur_addr + (ADDR_W'(burst_size) << 6);
                  state      <= S_DATA;
               end else if (err_now) begin
                  state <= S_ERROR;
               end
            end
            S_DATA: begin
               // An error only takes effect once the burst already announced on AW is complete.
               if (w_hs) begin
                  beats_left <= beats_left - 15'd1;
                  burst_left <= burst_left - 8'd1;
                  if (burst_left == 8'd1) begin
                     if (err_now)
                        state <= S_ERROR;
                     else if (beats_left == 15'd1)
                        state <= S_RESP;
                     else
                        state <= S_ADDR;
                  end
               end
            end
            S_RESP: begin
               if (err_now)
                  state <= S_ERROR;
               else if (outstanding == 15'd0)
                  state <= S_DONE;
            end
            S_ERROR: begin
               if (outstanding == 15'd0)
                  state <= S_DONE;
            end
            S_DONE:  state <= S_IDLE;
            default: state <= S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)
         outstanding <= '0;
      else if (aw_hs && !b_hs)
         outstanding <= outstanding + 15'd1;
      else if (b_hs && !aw_hs && (outstanding != 15'd0))
         outstanding <= outstanding - 15'd1;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wr_dest_clk_cnt   <= '0;
         wr_dest_valid_cnt <= '0;
      end else if (accept) begin
         wr_dest_clk_cnt   <= '0;
         wr_dest_valid_cnt <= '0;
      end else begin
         if (busy && (wr_dest_clk_cnt != 32'hFFFF_FFFF))
            wr_dest_clk_cnt <= wr_dest_clk_cnt + 32'd1;
         if (w_hs && (wr_dest_valid_cnt != 32'hFFFF_FFFF))
            wr_dest_valid_cnt <= wr_dest_valid_cnt + 32'd1;
      end
   end
endmodule

// File: tb/tb_dma_axi_mm_write_engine.sv
// Directed bench for dma_axi_mm_write_engine: a cycle-level AXI slave and source
// FIFO model run inside applyStimulus, with hand-computed expectations per step.
module tb_dma_axi_mm_write_engine;
   logic          clk;
   logic          reset_n;
   logic          desc_valid;
   logic          desc_ready;
   logic [47:0]   desc_dest_addr;
   logic [19:0]   desc_length;
   logic          src_valid;
   logic          src_ready;
   logic [511:0]  src_data;
   logic          awvalid;
   logic          awready;
   logic [47:0]   awaddr;
   logic [7:0]    awlen;
   logic          wvalid;
   logic          wready;
   logic [511:0]  wdata;
   logic [63:0]   wstrb;
   logic          wlast;
   logic          bvalid;
   logic          bready;
   logic [1:0]    bresp;
   logic          busy;
   logic          done;
   logic          wr_rsp_err;
   logic [1:0]    wr_resp_enc;
   logic [5:0]    wr_state;
   logic [31:0]   wr_dest_clk_cnt;
   logic [31:0]   wr_dest_valid_cnt;

   int total;
   int bad;

   int src_mode;
   int b_delay;
   int err_burst;

   int aw_cnt;
   int w_cnt;
   int wlast_cnt;
   int wlast_err;
   int done_cnt;
   int done_cyc;
   int accept_cyc;
   int last_b_cyc;
   int strb_bad;
   int order_err;
   int cross_cnt;
   int coincide;
   logic [63:0] last_strb;
   logic [47:0] aw_addr_q[$];
   logic [7:0]  aw_len_q[$];

   int  rst_done;
   bit  in_data;

   dma_axi_mm_write_engine dut (
      .clk               (clk),
      .reset_n           (reset_n),
      .desc_valid        (desc_valid),
      .desc_ready        (desc_ready),
      .desc_dest_addr    (desc_dest_addr),
      .desc_length       (desc_length),
      .src_valid         (src_valid),
      .src_ready         (src_ready),
      .src_data          (src_data),
      .awvalid           (awvalid),
      .awready           (awready),
      .awaddr            (awaddr),
      .awlen             (awlen),
      .wvalid            (wvalid),
      .wready            (wready),
      .wdata             (wdata),
      .wstrb             (wstrb),
      .wlast             (wlast),
      .bvalid            (bvalid),
      .bready            (bready),
      .bresp             (bresp),
      .busy              (busy),
      .done              (done),
      .wr_rsp_err        (wr_rsp_err),
      .wr_resp_enc       (wr_resp_enc),
      .wr_state          (wr_state),
      .wr_dest_clk_cnt   (wr_dest_clk_cnt),
      .wr_dest_valid_cnt (wr_dest_valid_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [511:0] beatWord(input int i);
      logic [31:0] w;
      w = 32'(i) ^ 32'hC0DE_0000;
      return {16{w}};
   endfunction

   function automatic logic [47:0] awAddrAt(input int i);
      return (aw_addr_q.size() > i) ? aw_addr_q[i] : '1;
   endfunction

   function automatic logic [7:0] awLenAt(input int i);
      return (aw_len_q.size() > i) ? aw_len_q[i] : 8'hEE;
   endfunction

   task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   // One descriptor end to end: drives source/AXI-slave inputs each negedge,
   // samples handshakes 1 ns later, stops 3 cycles after done or at budget.
   task automatic applyStimulus(input logic [47:0] addr, input logic [19:0] len, input int budget);
      int n_beats;
      int beat_idx;
      int b_id;
      int burst_beat;
      int b_due[$];
      bit accepted;
      n_beats    = (int'(len) + 63) / 64;
      aw_cnt     = 0;
      w_cnt      = 0;
      wlast_cnt  = 0;
      wlast_err  = 0;
      done_cnt   = 0;
      done_cyc   = -1;
      accept_cyc = -1;
      last_b_cyc = -1;
      strb_bad   = 0;
      order_err  = 0;
      cross_cnt  = 0;
      coincide   = 0;
      last_strb  = '0;
      aw_addr_q.delete();
      aw_len_q.delete();
      accepted   = 0;
      beat_idx   = 0;
      b_id       = 0;
      burst_beat = 0;
      desc_dest_addr = addr;
      desc_length    = len;
      for (int cyc = 0; cyc < budget; cyc++) begin
         @(negedge clk);
         desc_valid = !accepted;
         src_valid  = (src_mode == 0) ? 1'b1 : (cyc % 3 != 1);
         wready     = (src_mode == 0) ? 1'b1 : (cyc % 5 != 3);
         awready    = 1'b1;
         src_data   = beatWord(beat_idx);
         bvalid     = 1'b0;
         if (b_due.size() != 0)
            bvalid = (b_due[0] <= cyc);
         bresp = (bvalid && (b_id == err_burst)) ? 2'd2 : 2'd0;
         #1;
         if (desc_valid && desc_ready) begin
            accepted   = 1;
            accept_cyc = cyc;
         end
         if (awvalid && awready) begin
            aw_cnt++;
            aw_addr_q.push_back(awaddr);
            aw_len_q.push_back(awlen);
            if (int'(awaddr[11:0]) + (int'(awlen) + 1) * 64 > 4096)
               cross_cnt++;
         end
         if (wvalid && wready) begin
            if (wdata !== beatWord(w_cnt))
               order_err++;
            if (w_cnt == n_beats - 1)
               last_strb = wstrb;
            else if (wstrb !== '1)
               strb_bad++;
            burst_beat++;
            if (wlast) begin
               if (wlast_cnt >= aw_len_q.size())
                  wlast_err++;
               else if (burst_beat != int'(aw_len_q[wlast_cnt]) + 1)
                  wlast_err++;
               wlast_cnt++;
               burst_beat = 0;
               b_due.push_back(cyc + 1 + b_delay);
            end
            w_cnt++;
         end
         if (src_valid && src_ready)
            beat_idx++;
         if (bvalid && bready) begin
            void'(b_due.pop_front());
            b_id++;
            last_b_cyc = cyc;
         end
         if (awvalid && awready && bvalid && bready)
            coincide++;
         if (done) begin
            done_cnt++;
            done_cyc = cyc;
         end
         if ((done_cnt != 0) && (cyc >= done_cyc + 3))
            break;
      end
      desc_valid = 1'b0;
      bvalid     = 1'b0;
      src_valid  = 1'b0;
      wready     = 1'b0;
   endtask

   initial begin
      total = 0;
      bad   = 0;
      reset_n        = 1'b0;
      desc_valid     = 1'b0;
      desc_dest_addr = '0;
      desc_length    = '0;
      src_valid      = 1'b0;
      src_data       = '0;
      awready        = 1'b0;
      wready         = 1'b0;
      bvalid         = 1'b0;
      bresp          = 2'd0;
      src_mode       = 0;
      b_delay        = 2;
      err_burst      = -1;

      repeat (3) @(negedge clk);
      #1;
      checkOutput("rst_state",      64'(wr_state),        64'h01);
      checkOutput("rst_busy",       64'(busy),            64'd0);
      checkOutput("rst_desc_ready", 64'(desc_ready),      64'd0);
      checkOutput("rst_bready",     64'(bready),          64'd0);
      checkOutput("rst_clk_cnt",    64'(wr_dest_clk_cnt), 64'd0);
      @(negedge clk);
      reset_n = 1'b1;
      @(negedge clk);
      #1;
      checkOutput("idle_desc_ready", 64'(desc_ready), 64'd1);
      $display("[TB] reset checks complete");

      // 2 KB at 0x1000: two full 16-beat bursts
      applyStimulus(48'h1000, 20'd2048, 400);
      checkOutput("t1_aw_cnt",     64'(aw_cnt),            64'd2);
      checkOutput("t1_aw0_addr",   64'(awAddrAt(0)),       64'h1000);
      checkOutput("t1_aw0_len",    64'(awLenAt(0)),        64'd15);
      checkOutput("t1_aw1_addr",   64'(awAddrAt(1)),       64'h1400);
      checkOutput("t1_aw1_len",    64'(awLenAt(1)),        64'd15);
      checkOutput("t1_w_cnt",      64'(w_cnt),             64'd32);
      checkOutput("t1_strb_bad",   64'(strb_bad),          64'd0);
      checkOutput("t1_last_strb",  last_strb,              64'hFFFF_FFFF_FFFF_FFFF);
      checkOutput("t1_wlast_err",  64'(wlast_err),         64'd0);
      checkOutput("t1_done_cnt",   64'(done_cnt),          64'd1);
      checkOutput("t1_done_lat",   64'(done_cyc - accept_cyc), 64'd40);
      checkOutput("t1_valid_cnt",  64'(wr_dest_valid_cnt), 64'd32);
      checkOutput("t1_clk_cnt",    64'(wr_dest_clk_cnt),   64'd39);
      checkOutput("t1_rsp_err",    64'(wr_rsp_err),        64'd0);

      // 256 B at 0x0FC0: single beat up to the page edge, then 3 beats
      applyStimulus(48'h0FC0, 20'd256, 400);
      checkOutput("t2_aw_cnt",     64'(aw_cnt),      64'd2);
      checkOutput("t2_aw0_addr",   64'(awAddrAt(0)), 64'h0FC0);
      checkOutput("t2_aw0_len",    64'(awLenAt(0)),  64'd0);
      checkOutput("t2_aw1_addr",   64'(awAddrAt(1)), 64'h1000);
      checkOutput("t2_aw1_len",    64'(awLenAt(1)),  64'd2);
      checkOutput("t2_cross",      64'(cross_cnt),   64'd0);
      checkOutput("t2_w_cnt",      64'(w_cnt),       64'd4);
      checkOutput("t2_wlast_err",  64'(wlast_err),   64'd0);

      // 100 B at unaligned 0x2025: low address bits dropped, 36-byte tail
      applyStimulus(48'h2025, 20'd100, 400);
      checkOutput("t3_aw_cnt",     64'(aw_cnt),      64'd1);
      checkOutput("t3_aw0_addr",   64'(awAddrAt(0)), 64'h2000);
      checkOutput("t3_aw0_len",    64'(awLenAt(0)),  64'd1);
      checkOutput("t3_w_cnt",      64'(w_cnt),       64'd2);
      checkOutput("t3_strb_bad",   64'(strb_bad),    64'd0);
      checkOutput("t3_last_strb",  last_strb,        64'h0000_000F_FFFF_FFFF);
      checkOutput("t3_done_cnt",   64'(done_cnt),    64'd1);

      // 4 KB, SLVERR on the first burst's response, which lands during burst 2 data
      b_delay   = 3;
      err_burst = 0;
      applyStimulus(48'h0, 20'd4096, 400);
      checkOutput("t4_aw_cnt",       64'(aw_cnt),                64'd2);
      checkOutput("t4_w_cnt",        64'(w_cnt),                 64'd32);
      checkOutput("t4_rsp_err",      64'(wr_rsp_err),            64'd1);
      checkOutput("t4_resp_enc",     64'(wr_resp_enc),           64'd2);
      checkOutput("t4_done_cnt",     64'(done_cnt),              64'd1);
      checkOutput("t4_done_after_b", 64'(done_cyc > last_b_cyc), 64'd1);
      checkOutput("t4_valid_cnt",    64'(wr_dest_valid_cnt),     64'd32);
      err_burst = -1;
      b_delay   = 2;

      // Zero-length descriptor
      applyStimulus(48'h5000, 20'd0, 50);
      checkOutput("t5_done_lat",  64'(done_cyc - accept_cyc), 64'd2);
      checkOutput("t5_done_cnt",  64'(done_cnt),              64'd1);
      checkOutput("t5_aw_cnt",    64'(aw_cnt),                64'd0);
      checkOutput("t5_w_cnt",     64'(w_cnt),                 64'd0);
      checkOutput("t5_rsp_err",   64'(wr_rsp_err),            64'd0);
      checkOutput("t5_resp_enc",  64'(wr_resp_enc),           64'd0);

      // Source/wready stalls, B of burst 1 aligned with AW of burst 2
      src_mode = 1;
      b_delay  = 0;
      applyStimulus(48'h3000, 20'd2048, 600);
      checkOutput("t6_order_err", 64'(order_err),         64'd0);
      checkOutput("t6_w_cnt",     64'(w_cnt),             64'd32);
      checkOutput("t6_aw1_addr",  64'(awAddrAt(1)),       64'h3400);
      checkOutput("t6_coincide",  64'(coincide),          64'd1);
      checkOutput("t6_done_cnt",  64'(done_cnt),          64'd1);
      checkOutput("t6_valid_cnt", 64'(wr_dest_valid_cnt), 64'd32);
      src_mode = 0;
      b_delay  = 2;

      // Reset asserted while streaming data
      desc_dest_addr = 48'h0;
      desc_length    = 20'd4096;
      src_valid      = 1'b1;
      src_data       = beatWord(0);
      wready         = 1'b1;
      awready        = 1'b1;
      bvalid         = 1'b0;
      @(negedge clk);
      desc_valid = 1'b1;
      @(negedge clk);
      desc_valid = 1'b0;
      in_data = 0;
      for (int i = 0; i < 10 && !in_data; i++) begin
         @(negedge clk);
         #1;
         if (wr_state == 6'b000100)
            in_data = 1;
      end
      checkOutput("t7_reached_data", 64'(in_data), 64'd1);
      @(posedge clk);
      #2;
      reset_n = 1'b0;
      #1;
      checkOutput("t7_state",      64'(wr_state),          64'h01);
      checkOutput("t7_wvalid",     64'(wvalid),            64'd0);
      checkOutput("t7_src_ready",  64'(src_ready),         64'd0);
      checkOutput("t7_awvalid",    64'(awvalid),           64'd0);
      checkOutput("t7_wlast",      64'(wlast),             64'd0);
      checkOutput("t7_busy",       64'(busy),              64'd0);
      checkOutput("t7_desc_ready", 64'(desc_ready),        64'd0);
      checkOutput("t7_bready",     64'(bready),            64'd0);
      checkOutput("t7_valid_cnt",  64'(wr_dest_valid_cnt), 64'd0);
      checkOutput("t7_clk_cnt",    64'(wr_dest_clk_cnt),   64'd0);
      @(negedge clk);
      reset_n = 1'b1;
      rst_done = 0;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         #1;
         if (done)
            rst_done++;
      end
      checkOutput("t7_no_done",     64'(rst_done), 64'd0);
      checkOutput("t7_idle_after",  64'(wr_state), 64'h01);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
